// File: rtl/core_mem_pkg.sv
// Shared encodings for the unified-memory arbiter and its lane helper.
package core_mem_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_X = 2'd3} size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_IACC, ST_DACC, ST_RESP} state_e;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_e;
endpackage

// File: rtl/core_mem_lane.sv
// Byte-lane helper: byte enables, store replication, load extraction and alignment check.
module core_mem_lane
  import core_mem_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  input  logic        i_uns,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata_ext,
  output logic        o_misalign
);
  logic [31:0] w_sh;
  logic        w_sx;

  // Halves are always 2-aligned when legal, so one byte-granular shift serves both sizes.
  assign w_sh = i_rdata >> {i_lo, 3'b000};
  assign w_sx = ~i_uns;

  always_comb begin
    o_be        = 4'b0000;
    o_wdata_rep = 32'h0;
    o_rdata_ext = 32'h0;
    o_misalign  = 1'b0;
    case (i_size)
      SZ_B: begin
        o_be        = 4'b0001 << i_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_rdata_ext = {{24{w_sx & w_sh[7]}}, w_sh[7:0]};
      end
      SZ_H: begin
        o_misalign  = i_lo[0];
        o_be        = 4'b0011 << i_lo;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_rdata_ext = {{16{w_sx & w_sh[15]}}, w_sh[15:0]};
      end
      SZ_W: begin
        o_misalign  = |i_lo;
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
        o_rdata_ext = i_rdata;
      end
      default: o_misalign = 1'b1;  // illegal size is reported the same way as misalignment
    endcase
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store,
// with lane steering, load extension and a bounded wait for MEM_RDY.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [31:0]       I_RDATA,
  output logic              I_ACK,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [1:0]        D_SIZE,
  input  logic              D_UNSIGNED,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic [31:0]       D_RDATA,
  output logic              D_ACK,
  output logic              D_ERR,
  output logic              I_ERR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA,
  input  logic              MEM_RDY
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e            r_state, w_next;
  gnt_e              r_last, r_gnt, w_gnt;
  logic              w_grant, w_viol, w_to;
  logic [CNT_W-1:0]  r_cnt;
  size_e             r_size, w_l_size;
  logic [1:0]        r_lo, w_l_lo;
  logic              r_uns, r_we, r_err;
  logic [31:0]       r_rdata;
  logic [3:0]        w_l_be;
  logic [31:0]       w_l_wdata, w_l_rdata;
  logic              w_l_mis;
  logic              r_i_ack, r_d_ack, r_i_err, r_d_err, r_mem_req, r_mem_we;
  logic [31:0]       r_i_rdata, r_d_rdata, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;

  // While idle the lane looks at the live request; afterwards at the latched access.
  assign w_l_size = (r_state == ST_IDLE) ? size_e'(D_SIZE) : r_size;
  assign w_l_lo   = (r_state == ST_IDLE) ? D_ADDR[1:0]     : r_lo;

  core_mem_lane u_lane (
    .i_size      (w_l_size),
    .i_lo        (w_l_lo),
    .i_wdata     (D_WDATA),
    .i_rdata     (r_rdata),
    .i_uns       (r_uns),
    .o_be        (w_l_be),
    .o_wdata_rep (w_l_wdata),
    .o_rdata_ext (w_l_rdata),
    .o_misalign  (w_l_mis)
  );

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_gnt   = r_last;
    w_viol  = 1'b0;
    w_to    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The ACK cycle is dead time so a requester still holding REQ is not re-granted.
        if (!r_i_ack && !r_d_ack) begin
          if (I_REQ && D_REQ) begin
            w_grant = 1'b1;
            w_gnt   = (r_last == GNT_I) ? GNT_D : GNT_I;
          end else if (I_REQ) begin
            w_grant = 1'b1;
            w_gnt   = GNT_I;
          end else if (D_REQ) begin
            w_grant = 1'b1;
            w_gnt   = GNT_D;
          end
        end
        if (w_grant) begin
          w_viol = (w_gnt == GNT_I) ? (I_ADDR[1:0] != 2'b00) : w_l_mis;
          w_next = w_viol ? ST_RESP : ((w_gnt == GNT_I) ? ST_IACC : ST_DACC);
        end
      end
      ST_IACC, ST_DACC: begin
        if (MEM_RDY) begin
          w_next = ST_RESP;
        end else if (TIMEOUT != 0 && r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_to   = 1'b1;
          w_next = ST_RESP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_last      <= GNT_I;
      r_gnt       <= GNT_I;
      r_cnt       <= '0;
      r_size      <= SZ_W;
      r_lo        <= 2'b00;
      r_uns       <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_err     <= 1'b0;
      r_d_err     <= 1'b0;
      r_i_rdata   <= 32'h0;
      r_d_rdata   <= 32'h0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0;
    end else begin
      r_state <= w_next;
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_last <= w_gnt;
            r_gnt  <= w_gnt;
            r_err  <= w_viol;
            r_cnt  <= '0;
            if (w_gnt == GNT_I) begin
              r_size <= SZ_W;
              r_lo   <= 2'b00;
              r_uns  <= 1'b0;
              r_we   <= 1'b0;
            end else begin
              r_size <= size_e'(D_SIZE);
              r_lo   <= D_ADDR[1:0];
              r_uns  <= D_UNSIGNED;
              r_we   <= D_WE;
            end
            if (!w_viol) begin
              r_mem_req <= 1'b1;
              if (w_gnt == GNT_I) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= {I_ADDR[ADDR_W-1:2], 2'b00};
                r_mem_be    <= 4'b1111;
                r_mem_wdata <= 32'h0;
              end else begin
                r_mem_we    <= D_WE;
                r_mem_addr  <= {D_ADDR[ADDR_W-1:2], 2'b00};
                r_mem_be    <= w_l_be;
                r_mem_wdata <= w_l_wdata;
              end
            end
          end
        end
        ST_IACC, ST_DACC: begin
          if (MEM_RDY) begin
            r_rdata   <= MEM_RDATA;
            r_mem_req <= 1'b0;
          end else if (w_to) begin
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
          if (r_gnt == GNT_I) begin
            r_i_ack   <= 1'b1;
            r_i_err   <= r_err;
            r_i_rdata <= r_err ? 32'h0 : r_rdata;
          end else begin
            r_d_ack   <= 1'b1;
            r_d_err   <= r_err;
            r_d_rdata <= (r_err || r_we) ? 32'h0 : w_l_rdata;
          end
        end
      endcase
    end
  end

  assign I_ACK     = r_i_ack;
  assign I_ERR     = r_i_err;
  assign I_RDATA   = r_i_rdata;
  assign D_ACK     = r_d_ack;
  assign D_ERR     = r_d_err;
  assign D_RDATA   = r_d_rdata;
  assign MEM_REQ   = r_mem_req;
  assign MEM_WE    = r_mem_we;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_BE    = r_mem_be;
  assign MEM_WDATA = r_mem_wdata;
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one unified single-port memory between the core's instruction-fetch requester and its load/store requester.
- Arbitrates between the two requesters and sequences each access as a request/ready transaction.
- Generates byte enables and store-data lane placement for SB/SH/SW, and extracts and extends LB/LH/LW/LBU/LHU data.
- Bounds every access with a timeout. Sits between the multi-cycle core and the memory/bus.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- TIMEOUT, 255, max cycles waiting for MEM_RDY before aborting; 0 disables the timeout.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- I_REQ  in  1  fetch request; held high until I_ACK.
- I_ADDR  in  ADDR_W  fetch address; word aligned.
- I_RDATA  out  32  fetched instruction; valid when I_ACK=1.
- I_ACK  out  1  one-cycle completion pulse for the fetch.
- D_REQ  in  1  data request; held high until D_ACK.
- D_WE  in  1  1 = store, 0 = load.
- D_SIZE  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- D_UNSIGNED  in  1  zero-extend loads (LBU/LHU).
- D_ADDR  in  ADDR_W  byte address.
- D_WDATA  in  32  store data, right-aligned.
- D_RDATA  out  32  extended load data; valid with D_ACK.
- D_ACK  out  1  one-cycle completion pulse for the data access.
- D_ERR  out  1  qualifies D_ACK; misaligned, illegal size or timeout.
- I_ERR  out  1  qualifies I_ACK; misaligned fetch or timeout.
- MEM_REQ  out  1  memory access strobe; held until MEM_RDY.
- MEM_WE  out  1  write enable.
- MEM_ADDR  out  ADDR_W  word address, low 2 bits forced to 0.
- MEM_BE  out  4  byte enables.
- MEM_WDATA  out  32  lane-replicated store data.
- MEM_RDATA  in  32  read word; valid when MEM_RDY=1.
- MEM_RDY  in  1  one-cycle completion from memory.

Behaviour:
- Reset: state=IDLE, last_grant=I, timeout counter=0, and all outputs 0. A reset mid-access drops MEM_REQ the next cycle; no ACK is issued for that access.
- FSM states: IDLE, IACC, DACC, RESP.
- IDLE arbitration (round-robin):
  - Only one of I_REQ/D_REQ high: grant it.
  - Both high: grant the requester not in last_grant.
  - last_grant updates on grant.
- Alignment/size check (at grant, IDLE):
  - Data: half requires D_ADDR[0]=0; word requires D_ADDR[1:0]=0.
  - Fetch requires I_ADDR[1:0]=0.
  - D_SIZE=3 is illegal.
  - On any violation: skip memory, go to RESP with ERR=1.
- On grant without violation:
  - Register address, BE and WDATA.
  - Go to IACC or DACC; MEM_REQ is high from the next cycle.
- Byte enables:
  - Byte: 4'b0001 << ADDR[1:0].
  - Half: 4'b0011 << ADDR[1:0].
  - Word: 4'b1111.
  - Fetch: 4'b1111 with MEM_WE=0.
- MEM_WDATA: byte = {4{WDATA[7:0]}}, half = {2{WDATA[15:0]}}, word = WDATA.
- IACC/DACC:
  - Hold MEM_* stable.
  - On MEM_RDY, capture MEM_RDATA and go to RESP.
  - The counter increments each waiting cycle. If it reaches TIMEOUT with no MEM_RDY, drop MEM_REQ and go to RESP with ERR=1.
  - MEM_RDY in the same cycle as the timeout wins (success).
- Load extraction: select the byte/half by ADDR[1:0]; sign-extend unless D_UNSIGNED. Stores return D_RDATA=0.
- RESP:
  - Pulse exactly one of I_ACK/D_ACK for 1 cycle, with data and ERR.
  - Clear the counter and return to IDLE.
  - Min latency is grant → ACK = 3 cycles with MEM_RDY on the first MEM_REQ cycle; errors take 2 cycles.
- Requests seen while busy are ignored until IDLE. A requester that drops REQ before its ACK is a protocol violation; the arbiter still completes the access.
- MEM_RDY while idle is ignored.

Decomposition:
- Shared package core_mem_pkg:
  - Size encodings SZ_B/SZ_H/SZ_W.
  - FSM state encodings.
  - Grant ids GNT_I/GNT_D.
- Sub-module core_mem_lane: purely combinational; {size, addr[1:0], wdata, rdata, unsigned} → {be, wdata_rep, rdata_ext, misalign}. Reused later by a cache.

Test Plan:
1. Fetch only: I_REQ, I_ADDR=0x100, MEM_RDY one cycle after MEM_REQ with RDATA=0x00500093 → I_ACK 1 cycle, I_RDATA=0x00500093, I_ERR=0, MEM_BE=4'hF, MEM_WE=0.
2. Simultaneous I_REQ and D_REQ after reset (last_grant=I) → data granted first, then fetch. Repeat → order alternates.
3. SB: D_ADDR=0x203, D_WDATA=0xAB → MEM_ADDR=0x200, MEM_BE=4'b1000, MEM_WDATA=0xABABABAB, D_ACK with D_ERR=0.
4. LB then LBU at 0x202 with MEM_RDATA=0x0080FF00 → D_RDATA=0xFFFFFF80, then 0x00000080.
5. LW at 0x206 → no MEM_REQ, D_ACK+D_ERR 2 cycles after grant. Fetch at 0x102 → I_ACK+I_ERR.
6. TIMEOUT=4 with MEM_RDY never asserted → MEM_REQ high 4 cycles then low, D_ACK+D_ERR. Next, assert RST during DACC → MEM_REQ low next cycle and no ACK.
